pc_branch_unit: RTL and testbench

//  Program-counter / branch-resolution stage of the 8-bit core, directly downstream of the ALU.
//  - Latches the ALU compare outputs (equal, less) into architectural flags.
//  - Resolves conditional branches against those flags, using an absolute-target lookup table.
//  - Advances, holds or redirects the PC and runs the start/halt/done control for a program run.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/branch_lut.sv | 44 ++++
 rtl/pc_branch_unit.sv | 134 +++++++++++++
 tb/tb_pc_branch_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cpu_pkg : shared types for the 8-bit core PC / branch stage        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package cpu_pkg;

   localparam int PC_W = 10;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } pc_state_t;

   typedef enum logic [1:0] {
      BR_AL = 2'd0,
      BR_EQ = 2'd1,
      BR_LT = 2'd2,
      BR_GE = 2'd3
   } br_cond_t;

endpackage
`default_nettype wire

// File: rtl/branch_lut.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | branch_lut : absolute branch-target table, 1 sync write, 1 comb rd |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module branch_lut #(
   parameter int PC_W      = 10,
   parameter int LUT_DEPTH = 16,
   parameter int IDX_W     = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [PC_W-1:0]  wr_data,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [PC_W-1:0]  rd_data
);

   logic [PC_W-1:0] mem_q [LUT_DEPTH];
   logic [PC_W-1:0] mem_d [LUT_DEPTH];

   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         mem_d[wr_idx] = wr_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < LUT_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   // Read returns the pre-edge contents, so a same-cycle write is not seen.
   assign rd_data = mem_q[rd_idx];

endmodule
`default_nettype wire

// File: rtl/pc_branch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pc_branch_unit : PC sequencing, flag latch and branch resolution   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pc_branch_unit #(
   parameter int PC_W      = cpu_pkg::PC_W,
   parameter int LUT_DEPTH = 16,
   parameter int IDX_W     = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stall,
   input  logic             halt,
   input  logic             cmp_valid,
   input  logic             alu_equal,
   input  logic             alu_less,
   input  logic             branch,
   input  logic [1:0]       br_cond,
   input  logic [IDX_W-1:0] br_idx,
   input  logic             lut_wr_en,
   input  logic [IDX_W-1:0] lut_wr_idx,
   input  logic [PC_W-1:0]  lut_wr_data,
   output logic [PC_W-1:0]  pc,
   output logic             eq_flag,
   output logic             lt_flag,
   output logic             taken,
   output logic             done
);

   import cpu_pkg::*;

   pc_state_t       state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            eq_q, eq_d;
   logic            lt_q, lt_d;
   logic            taken_q, taken_d;
   logic [PC_W-1:0] w_target;
   logic            w_cond_true;

   branch_lut #(
      .PC_W      (PC_W),
      .LUT_DEPTH (LUT_DEPTH),
      .IDX_W     (IDX_W)
   ) u_lut (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (lut_wr_en),
      .wr_idx  (lut_wr_idx),
      .wr_data (lut_wr_data),
      .rd_idx  (br_idx),
      .rd_data (w_target)
   );

   // Conditions use the registered flags, never this cycle's ALU result.
   always_comb begin
      w_cond_true = 1'b0;
      case (br_cond_t'(br_cond))
         BR_AL: w_cond_true = 1'b1;
         BR_EQ: w_cond_true = eq_q;
         BR_LT: w_cond_true = lt_q;
         BR_GE: w_cond_true = ~lt_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      eq_d    = eq_q;
      lt_d    = lt_q;
      taken_d = 1'b0;
      if (!stall) begin
         case (state_q)
            IDLE: begin
               pc_d = '0;
               if (start) begin
                  state_d = RUN;
               end
            end
            RUN: begin
               if (cmp_valid) begin
                  eq_d = alu_equal;
                  lt_d = alu_less;
               end
               if (halt) begin
                  state_d = HALTED;
               end else if (branch && w_cond_true) begin
                  pc_d    = w_target;
                  taken_d = 1'b1;
               end else begin
                  pc_d = pc_q + PC_W'(1);
               end
            end
            HALTED: begin
               if (start) begin
                  state_d = RUN;
                  pc_d    = '0;
                  eq_d    = 1'b0;
                  lt_d    = 1'b0;
               end
            end
            default: begin
               state_d = IDLE;
               pc_d    = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         pc_q    <= '0;
         eq_q    <= 1'b0;
         lt_q    <= 1'b0;
         taken_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         eq_q    <= eq_d;
         lt_q    <= lt_d;
         taken_q <= taken_d;
      end
   end

   assign pc      = pc_q;
   assign eq_flag = eq_q;
   assign lt_flag = lt_q;
   assign taken   = taken_q;
   assign done    = (state_q == HALTED);

endmodule
`default_nettype wire

// File: tb/tb_pc_branch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pc_branch_unit : directed vector bench for pc_branch_unit       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_pc_branch_unit;

   localparam int PC_W  = 10;
   localparam int IDX_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             start, stall, halt, cmp_valid, alu_equal, alu_less, branch;
   logic [1:0]       br_cond;
   logic [IDX_W-1:0] br_idx;
   logic             lut_wr_en;
   logic [IDX_W-1:0] lut_wr_idx;
   logic [PC_W-1:0]  lut_wr_data;
   logic [PC_W-1:0]  pc;
   logic             eq_flag, lt_flag, taken, done;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pc_branch_unit #(.PC_W(PC_W), .LUT_DEPTH(16), .IDX_W(IDX_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .stall       (stall),
      .halt        (halt),
      .cmp_valid   (cmp_valid),
      .alu_equal   (alu_equal),
      .alu_less    (alu_less),
      .branch      (branch),
      .br_cond     (br_cond),
      .br_idx      (br_idx),
      .lut_wr_en   (lut_wr_en),
      .lut_wr_idx  (lut_wr_idx),
      .lut_wr_data (lut_wr_data),
      .pc          (pc),
      .eq_flag     (eq_flag),
      .lt_flag     (lt_flag),
      .taken       (taken),
      .done        (done)
   );

   typedef struct {
      logic             start, stall, halt, cmp_valid, alu_equal, alu_less, branch;
      logic [1:0]       br_cond;
      logic [IDX_W-1:0] br_idx;
      logic             lut_wr_en;
      logic [IDX_W-1:0] lut_wr_idx;
      logic [PC_W-1:0]  lut_wr_data;
      logic [PC_W-1:0]  exp_pc;
      logic             exp_eq, exp_lt, exp_taken, exp_done;
   } vec_t;

   vec_t vecs[$];

   // Control bits packed as {start,stall,halt,cmp_valid,alu_equal,alu_less,branch}.
   function automatic vec_t mk(input logic [6:0] ctl, input logic [1:0] cond,
                               input int idx, input logic we, input int widx, input int wdata,
                               input int epc, input logic eeq, input logic elt,
                               input logic etk, input logic edn);
      vec_t v;
      {v.start, v.stall, v.halt, v.cmp_valid, v.alu_equal, v.alu_less, v.branch} = ctl;
      v.br_cond     = cond;
      v.br_idx      = IDX_W'(idx);
      v.lut_wr_en   = we;
      v.lut_wr_idx  = IDX_W'(widx);
      v.lut_wr_data = PC_W'(wdata);
      v.exp_pc      = PC_W'(epc);
      v.exp_eq      = eeq;
      v.exp_lt      = elt;
      v.exp_taken   = etk;
      v.exp_done    = edn;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d] got=%0h want=%0h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      start       = v.start;
      stall       = v.stall;
      halt        = v.halt;
      cmp_valid   = v.cmp_valid;
      alu_equal   = v.alu_equal;
      alu_less    = v.alu_less;
      branch      = v.branch;
      br_cond     = v.br_cond;
      br_idx      = v.br_idx;
      lut_wr_en   = v.lut_wr_en;
      lut_wr_idx  = v.lut_wr_idx;
      lut_wr_data = v.lut_wr_data;
   endtask

   task automatic check_outs(input string name, input int idx, input vec_t v);
      chk({name, "_pc"},    idx, int'(pc),      int'(v.exp_pc));
      chk({name, "_eq"},    idx, int'(eq_flag), int'(v.exp_eq));
      chk({name, "_lt"},    idx, int'(lt_flag), int'(v.exp_lt));
      chk({name, "_taken"}, idx, int'(taken),   int'(v.exp_taken));
      chk({name, "_done"},  idx, int'(done),    int'(v.exp_done));
   endtask

   task automatic step(input string name, input int idx, input vec_t v);
      @(negedge clk);
      drive(v);
      @(posedge clk);
      #1;
      check_outs(name, idx, v);
   endtask

   initial begin
      vec_t nop;
      nop = mk(7'b0000000, 2'd0, 0, 1'b0, 0, 0, 0, 0, 0, 0, 0);
      drive(nop);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_outs("reset", 0, nop);
      @(negedge clk);
      reset = 1'b0;

      //           ctl(s,st,h,cv,ae,al,b) cond idx we widx wdata  pc    eq lt tk dn
      vecs.push_back(mk(7'b0001110, 2'd0, 0, 0, 0, 0,     0,     0, 0, 0, 0)); // idle ignores cmp
      vecs.push_back(mk(7'b1000000, 2'd0, 0, 0, 0, 0,     0,     0, 0, 0, 0)); // start
      vecs.push_back(mk(7'b0000000, 2'd0, 0, 0, 0, 0,     1,     0, 0, 0, 0));
      vecs.push_back(mk(7'b0000000, 2'd0, 0, 0, 0, 0,     2,     0, 0, 0, 0));
      vecs.push_back(mk(7'b0000000, 2'd0, 0, 0, 0, 0,     3,     0, 0, 0, 0));
      vecs.push_back(mk(7'b0000000, 2'd0, 0, 0, 0, 0,     4,     0, 0, 0, 0));
      vecs.push_back(mk(7'b0000000, 2'd0, 0, 0, 0, 0,     5,     0, 0, 0, 0));
      vecs.push_back(mk(7'b0000000, 2'd0, 0, 1, 3, 'h100, 6,     0, 0, 0, 0)); // LUT[3]=0x100
      vecs.push_back(mk(7'b0001100, 2'd0, 0, 0, 0, 0,     7,     1, 0, 0, 0)); // cmp 5==5
      vecs.push_back(mk(7'b0000001, 2'd1, 3, 0, 0, 0,     'h100, 1, 0, 1, 0)); // BR_EQ taken
      vecs.push_back(mk(7'b0001010, 2'd0, 0, 0, 0, 0,     'h101, 0, 1, 0, 0)); // cmp 4<5
      vecs.push_back(mk(7'b0000001, 2'd1, 3, 0, 0, 0,     'h102, 0, 1, 0, 0)); // BR_EQ not taken
      vecs.push_back(mk(7'b0001101, 2'd1, 3, 0, 0, 0,     'h103, 1, 0, 0, 0)); // old flags used
      vecs.push_back(mk(7'b0000001, 2'd2, 3, 0, 0, 0,     'h104, 1, 0, 0, 0)); // BR_LT not taken
      vecs.push_back(mk(7'b0000001, 2'd3, 3, 0, 0, 0,     'h100, 1, 0, 1, 0)); // BR_GE taken
      vecs.push_back(mk(7'b0000001, 2'd0, 5, 1, 5, 'h3FF, 0,     1, 0, 1, 0)); // same-cycle wr: old 0
      vecs.push_back(mk(7'b0000001, 2'd0, 5, 0, 0, 0,     'h3FF, 1, 0, 1, 0)); // to 0x3FF
      vecs.push_back(mk(7'b0111011, 2'd0, 5, 0, 0, 0,     'h3FF, 1, 0, 0, 0)); // stall
      vecs.push_back(mk(7'b1100000, 2'd0, 0, 1, 7, 7,     'h3FF, 1, 0, 0, 0)); // stall + LUT wr
      vecs.push_back(mk(7'b0100000, 2'd0, 0, 0, 0, 0,     'h3FF, 1, 0, 0, 0)); // stall
      vecs.push_back(mk(7'b0000000, 2'd0, 0, 0, 0, 0,     0,     1, 0, 0, 0)); // wrap
      vecs.push_back(mk(7'b0000001, 2'd0, 7, 0, 0, 0,     7,     1, 0, 1, 0)); // to 7
      vecs.push_back(mk(7'b0010000, 2'd0, 0, 0, 0, 0,     7,     1, 0, 0, 1)); // halt
      vecs.push_back(mk(7'b0001010, 2'd0, 0, 0, 0, 0,     7,     1, 0, 0, 1)); // halted ignores cmp
      vecs.push_back(mk(7'b1000000, 2'd0, 0, 0, 0, 0,     0,     0, 0, 0, 0)); // restart
      vecs.push_back(mk(7'b1000000, 2'd0, 0, 0, 0, 0,     1,     0, 0, 0, 0)); // start in RUN
      vecs.push_back(mk(7'b0001100, 2'd0, 0, 0, 0, 0,     2,     1, 0, 0, 0));
      vecs.push_back(mk(7'b0000001, 2'd0, 7, 0, 0, 0,     7,     1, 0, 1, 0)); // taken before reset

      for (int i = 0; i < vecs.size(); i++) begin
         step("vec", i, vecs[i]);
      end

      // Asynchronous reset between edges, mid-run with taken and eq_flag high.
      #2;
      drive(nop);
      reset = 1'b1;
      #1;
      check_outs("async_rst", 0, nop);
      @(negedge clk);
      reset = 1'b0;
      step("post_rst", 0, mk(7'b1000000, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      // LUT[7] was cleared by reset, so the branch lands on 0.
      step("post_rst", 1, mk(7'b0000001, 2'd0, 7, 0, 0, 0, 0, 0, 0, 1, 0));
      step("post_rst", 2, nop_run(1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   function automatic vec_t nop_run(input int epc);
      return mk(7'b0000000, 2'd0, 0, 0, 0, 0, epc, 0, 0, 0, 0);
   endfunction

endmodule
`default_nettype wire
